// File: rtl/apb_pkg.sv
// Shared types and widths for the APB master bridge and its command FIFO.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Requester command/response handshake plus APB bus signals of the bridge.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;

    logic [ADDR_W-1:0] apb_addr;
    logic [DATA_W-1:0] apb_wdata;
    logic              apb_write;
    logic              apb_sel;
    logic              apb_enable;
    logic [DATA_W-1:0] apb_rdata;

    // Bridge side: takes commands, drives the APB bus and responses.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, apb_rdata,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
        output apb_addr, apb_wdata, apb_write, apb_sel, apb_enable
    );

    // Environment side: requester plus APB responder.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, apb_rdata,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
        input  apb_addr, apb_wdata, apb_write, apb_sel, apb_enable
    );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; head is visible on dout_o without a pop.
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  logic     pop_i,
    input  apb_cmd_t din_i,
    output apb_cmd_t dout_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    apb_cmd_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: queues requester commands and runs each as one SETUP + one ACCESS cycle.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                clock,
    input  logic                reset,
    apb_master_bridge_if.master bus
);

    apb_cmd_t fifo_din, fifo_dout;
    logic     fifo_full, fifo_empty;
    logic     push, pop, start;

    apb_state_e        state_q, state_d;
    logic              sel_q, sel_d;
    logic              enable_q, enable_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    // Held low during reset so nothing is accepted while state is being cleared.
    assign bus.cmd_ready = ~reset & ~fifo_full;
    assign push          = bus.cmd_valid & bus.cmd_ready;

    assign fifo_din = '{write: bus.cmd_write,
                        addr:  APB_ADDR_W'(bus.cmd_addr),
                        wdata: APB_DATA_W'(bus.cmd_wdata)};

    apb_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        enable_d    = enable_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        pop         = 1'b0;
        start       = 1'b0;

        case (state_q)
            IDLE: begin
                start = ~fifo_empty;
            end
            SETUP: begin
                enable_d = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                rsp_valid_d = 1'b1;
                rsp_write_d = write_q;
                rsp_rdata_d = write_q ? '0 : DATA_W'(bus.apb_rdata);
                start       = ~fifo_empty;
                if (fifo_empty) begin
                    sel_d    = 1'b0;
                    enable_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Launch the next transfer; sel stays high on a back-to-back launch.
        if (start) begin
            pop      = 1'b1;
            write_d  = fifo_dout.write;
            addr_d   = ADDR_W'(fifo_dout.addr);
            wdata_d  = DATA_W'(fifo_dout.wdata);
            sel_d    = 1'b1;
            enable_d = 1'b0;
            state_d  = SETUP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            enable_q    <= enable_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.apb_sel    = sel_q;
    assign bus.apb_enable = enable_q;
    assign bus.apb_write  = write_q;
    assign bus.apb_addr   = addr_q;
    assign bus.apb_wdata  = wdata_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_write  = rsp_write_q;
    assign bus.rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge against a transfer-schedule reference model.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_bridge #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    // One accepted command: p = cycle it was accepted, s = cycle its SETUP is on the bus.
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          p;
        int          s;
    } mcmd_t;

    mcmd_t       q[$];
    logic [31:0] rdata_at [int];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_rsp_obs = 0;
    int          n_rsp_exp = 0;
    bit          last_push = 1'b0;
    bit          force_rd = 1'b0;
    logic [31:0] forced_rd = 32'h0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Check the current cycle against the model, record any push, then advance one clock.
    task automatic tick();
        int          occ;
        int          idx;
        int          ns;
        logic        esel, een, ew, erv, erw;
        logic [31:0] ea, ed, erd;
        @(negedge clk);
        rdata_at[cyc] = bus.apb_rdata;

        occ = 0;
        foreach (q[i]) if (q[i].p + 1 <= cyc && cyc <= q[i].s - 1) occ++;
        idx = -1;
        foreach (q[i]) if (q[i].s <= cyc) idx = i;

        esel = 1'b0; een = 1'b0; ew = 1'b0; ea = '0; ed = '0;
        if (idx >= 0) begin
            ew = q[idx].w; ea = q[idx].a; ed = q[idx].d;
            if (cyc <= q[idx].s + 1) begin
                esel = 1'b1;
                een  = (cyc == q[idx].s + 1);
            end
        end
        erv = 1'b0; erw = 1'b0; erd = '0;
        foreach (q[i]) begin
            if (cyc == q[i].s + 2) begin
                erv = 1'b1;
                erw = q[i].w;
                erd = q[i].w ? 32'h0 : rdata_at[q[i].s + 1];
            end
        end

        check_eq("cmd_ready",  64'(bus.cmd_ready),  64'(!rst && occ < DEPTH));
        check_eq("apb_sel",    64'(bus.apb_sel),    64'(esel));
        check_eq("apb_enable", 64'(bus.apb_enable), 64'(een));
        check_eq("apb_write",  64'(bus.apb_write),  64'(ew));
        check_eq("apb_addr",   64'(bus.apb_addr),   64'(ea));
        check_eq("apb_wdata",  64'(bus.apb_wdata),  64'(ed));
        check_eq("rsp_valid",  64'(bus.rsp_valid),  64'(erv));
        if (erv) begin
            check_eq("rsp_write", 64'(bus.rsp_write), 64'(erw));
            check_eq("rsp_rdata", 64'(bus.rsp_rdata), 64'(erd));
            n_rsp_exp++;
        end
        if (bus.rsp_valid === 1'b1) n_rsp_obs++;

        last_push = (bus.cmd_valid === 1'b1) && !rst && (occ < DEPTH);
        if (last_push) begin
            ns = cyc + 2;
            if (q.size() > 0 && q[q.size()-1].s + 2 > ns) ns = q[q.size()-1].s + 2;
            q.push_back('{w: bus.cmd_write, a: bus.cmd_addr, d: bus.cmd_wdata, p: cyc, s: ns});
        end
        if (rst) q.delete();

        @(posedge clk);
        cyc++;
        #1;
        bus.apb_rdata = force_rd ? forced_rd : $urandom();
    endtask

    // Present a command and hold it until the model says it was accepted.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (last_push) break;
        end
        if (!last_push) check_eq("push_timeout", 64'(0), 64'(1));
        bus.cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int target;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.apb_rdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        idle(2);

        // Single write, then single read with a fixed responder value.
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        idle(6);
        force_rd  = 1'b1;
        forced_rd = 32'h1234_5678;
        send(1'b0, 32'h0000_0020, 32'h0);
        idle(6);
        force_rd = 1'b0;

        // Back-to-back W, R, W followed by a long idle hold.
        send(1'b1, 32'h0, 32'hA0A0_0001);
        send(1'b0, 32'h4, 32'h0);
        send(1'b1, 32'h8, 32'hA0A0_0003);
        idle(16);

        // Seven commands with valid held high to fill the FIFO.
        for (int i = 0; i < 7; i++) send(i[0], 32'h100 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
        idle(20);

        // Reset during the ACCESS of the first of three queued commands.
        send(1'b1, 32'h200, 32'h1111_1111);
        send(1'b0, 32'h204, 32'h0);
        send(1'b1, 32'h208, 32'h3333_3333);
        target = q[q.size()-3].s + 1;
        for (int k = 0; k < 10 && cyc < target; k++) tick();
        check_eq("reset_at_access", 64'(bus.apb_enable), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(10);

        // Random traffic with occasional resets.
        for (int k = 0; k < 800; k++) begin
            bus.cmd_valid = ($urandom_range(99) < 60);
            bus.cmd_write = 1'($urandom());
            bus.cmd_addr  = $urandom() & 32'hFFFF_FFFC;
            bus.cmd_wdata = $urandom();
            rst = ($urandom_range(249) == 0);
            tick();
        end
        rst = 1'b0;
        idle(30);
        check_eq("rsp_count", 64'(n_rsp_obs), 64'(n_rsp_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
